// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle press/release/click/long/repeat events.
// A button already down at reset is locked out until it is seen released.
module button_event #(
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000,
    parameter int unsigned CNT_WIDTH     = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam logic [1:0] StLockout = 2'd0;
    localparam logic [1:0] StIdle    = 2'd1;
    localparam logic [1:0] StPressed = 2'd2;
    localparam logic [1:0] StRepeat  = 2'd3;

    // Terminal counts are truncated to the counter width; parameters must fit.
    localparam logic [CNT_WIDTH-1:0] HoldLast   = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RepeatLast = CNT_WIDTH'(REPEAT_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 held_q, held_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 click_q, click_d;
    logic                 long_q, long_d;
    logic                 repeat_q, repeat_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            StLockout: begin
                if (!din) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (din) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            StPressed: begin
                // Release wins over the terminal count on the same edge.
                if (!din) begin
                    state_d   = StIdle;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRepeat;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRepeat: begin
                if (!din) begin
                    state_d   = StIdle;
                    release_d = 1'b1;
                end else if (cnt_q == RepeatLast) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StLockout;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == StPressed) || (state_d == StRepeat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StLockout;
            cnt_q     <= '0;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign held          = held_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click_pulse   = click_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: directed scenarios with literal expectations plus random din runs,
// all outputs compared every cycle against a hold-length model.
module tb_button_event;

    localparam int unsigned Hold = 8;
    localparam int unsigned Rep  = 4;
    localparam int unsigned W    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic held, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    button_event #(
        .HOLD_CYCLES  (Hold),
        .REPEAT_CYCLES(Rep),
        .CNT_WIDTH    (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .held         (held),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .click_pulse  (click_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    // Model: n = edges elapsed since the accepted press edge while the button stays down.
    bit   m_locked = 1'b1;
    bit   m_down   = 1'b0;
    int   n        = 0;
    logic e_held = 0, e_press = 0, e_rel = 0, e_click = 0, e_long = 0, e_rep = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_locked = 1'b1;
            m_down   = 1'b0;
            n        = 0;
            {e_held, e_press, e_rel, e_click, e_long, e_rep} = '0;
        end else begin
            {e_press, e_rel, e_click, e_long, e_rep} = '0;
            if (m_locked) begin
                if (!din) m_locked = 1'b0;
            end else if (!m_down) begin
                if (din) begin
                    m_down  = 1'b1;
                    n       = 0;
                    e_press = 1'b1;
                end
            end else if (!din) begin
                m_down  = 1'b0;
                e_rel   = 1'b1;
                e_click = (n < int'(Hold));
            end else begin
                n = n + 1;
                if (n == int'(Hold)) e_long = 1'b1;
                else if (n > int'(Hold) && ((n - int'(Hold)) % int'(Rep)) == 0) e_rep = 1'b1;
            end
            e_held = m_down;
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("model_held", held, e_held);
            chk("model_press", press_pulse, e_press);
            chk("model_release", release_pulse, e_rel);
            chk("model_click", click_pulse, e_click);
            chk("model_long", long_pulse, e_long);
            chk("model_repeat", repeat_pulse, e_rep);
        end
    end

    // Apply d (called at posedge+1), let the next edge sample it, return at that edge+1.
    task automatic cyc(input logic d);
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic d);
        din = d;
        #2 rst = 1'b1;
        #1;
        chk("reset_held", held, 1'b0);
        chk("reset_pulses", |{press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse},
            1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int len;
        logic lvl;
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;

        // Short click
        do_reset(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        chk("click_press", press_pulse, 1'b1);
        chk("click_held_k1", held, 1'b1);
        cyc(1'b1);
        chk("click_press_once", press_pulse, 1'b0);
        cyc(1'b1);
        chk("click_held_k3", held, 1'b1);
        cyc(1'b0);
        chk("click_release", release_pulse, 1'b1);
        chk("click_click", click_pulse, 1'b1);
        chk("click_held_off", held, 1'b0);

        // Long hold with repeat
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1);
            if (i == 8) chk("long_at_k8", long_pulse, 1'b1);
            if (i == 7) chk("long_not_k7", long_pulse, 1'b0);
            if (i == 12 || i == 16) chk("repeat_at", repeat_pulse, 1'b1);
            if (i == 13 || i == 19) chk("repeat_not", repeat_pulse, 1'b0);
        end
        cyc(1'b0);
        chk("long_release", release_pulse, 1'b1);
        chk("long_no_click", click_pulse, 1'b0);

        // Boundary release: low sampled on the would-be long edge
        cyc(1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1);
        cyc(1'b0);
        chk("bound_release", release_pulse, 1'b1);
        chk("bound_click", click_pulse, 1'b1);
        chk("bound_no_long", long_pulse, 1'b0);

        // Single-sample glitch
        cyc(1'b0);
        cyc(1'b1);
        chk("glitch_press", press_pulse, 1'b1);
        chk("glitch_no_rel", release_pulse, 1'b0);
        cyc(1'b0);
        chk("glitch_release", release_pulse, 1'b1);
        chk("glitch_click", click_pulse, 1'b1);
        chk("glitch_no_press", press_pulse, 1'b0);

        // Lockout: button held through reset
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1);
            chk("lock_no_press", press_pulse, 1'b0);
            chk("lock_no_held", held, 1'b0);
        end
        cyc(1'b0);
        cyc(1'b1);
        chk("lock_then_press", press_pulse, 1'b1);

        // Async reset mid-REPEAT, landing on a repeat_pulse cycle
        for (int i = 1; i <= 12; i++) cyc(1'b1);
        chk("pre_rst_repeat", repeat_pulse, 1'b1);
        chk("pre_rst_held", held, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_held", held, 1'b0);
        chk("async_repeat", repeat_pulse, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1);
            chk("post_rst_no_press", press_pulse, 1'b0);
        end
        cyc(1'b0);

        // Random runs of highs/lows, long enough to reach several repeats
        lvl = 1'b0;
        for (int r = 0; r < 300; r++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) cyc(lvl);
            if ($urandom_range(0, 40) == 0) do_reset(lvl);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
